// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: datapath width, PC alignment
// mask and the fetch FSM state encoding.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_t;

  // Force a PC onto a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// Capture register for the instruction/PC pair presented to decode.
// Loads on 'load', otherwise holds; asynchronous active-high reset to zero.
module fetch_hold_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] instr_d,
  input  logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] instr_q,
  output logic [XLEN-1:0] pc_q
);

  // Hold the last captured pair until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (load) begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: rtl/pc_next_seq.sv
// Next-PC sequencer / fetch controller feeding the PC register D input.
// One memory request per PC, pair held for decode under valid/ready,
// branch redirects take priority over the handshake.
// Optional build macro: MISALIGN_TRAP_EN adds sticky output misalign_err.
module pc_next_seq
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misalign_err
`endif
);

  fetch_state_t state_q, state_d;
  logic         redirect;
  logic         hold_load;

  // Redirects are ignored while booting.
  assign redirect = br_taken && (state_q != BOOT);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // Next-state decode; redirect outranks the memory/decode handshakes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:  state_d = ISSUE;
      ISSUE: state_d = redirect ? DRAIN : WAIT;
      WAIT: begin
        if (redirect)         state_d = imem_rvalid ? ISSUE : DRAIN;
        else if (imem_rvalid) state_d = HOLD;
      end
      HOLD: begin
        if (redirect || if_ready) state_d = ISSUE;
      end
      DRAIN: begin
        if (!redirect && imem_rvalid) state_d = ISSUE;
      end
      default: state_d = BOOT;
    endcase
  end

  // Output decode; pc_next re-drives pc_cur whenever fetch must not advance.
  always_comb begin
    imem_req  = (state_q == ISSUE);
    imem_addr = pc_cur;
    if_valid  = (state_q == HOLD);
    hold_load = (state_q == WAIT) && imem_rvalid && !redirect;
    pc_next   = pc_cur;
    if (state_q == BOOT)                 pc_next = RESET_PC;
    else if (redirect)                   pc_next = align_pc(br_target);
    else if (state_q == HOLD && if_ready) pc_next = pc_cur + PC_STEP;
  end

  fetch_hold_reg u_hold (
    .clk     (CLK),
    .rst     (RST),
    .load    (hold_load),
    .instr_d (imem_rdata),
    .pc_d    (pc_cur),
    .instr_q (if_instr),
    .pc_q    (if_pc)
  );

`ifdef MISALIGN_TRAP_EN
  // Sticky flag for redirects to non-word-aligned targets; only reset clears it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                misalign_err <= 1'b0;
    else if (redirect && br_target[1:0] != 2'b00) misalign_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pc_next_seq.sv
// Self-checking bench for pc_next_seq: PC register and instruction memory
// are modelled here; expectations come from a flag-based fetch model.
module tb_pc_next_seq;

  localparam logic [31:0] RPC0  = 32'h0000_0000;
  localparam logic [31:0] RPC2  = 32'hFFFF_FFFC;
  localparam logic [31:0] MAGIC = 32'hDEAD_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] pc_cur, pc_next, imem_addr, imem_rdata, if_instr, if_pc, br_target;
  logic        imem_req, imem_rvalid, if_valid, if_ready, br_taken;
  logic [31:0] pc_cur2, pc_next2, imem_addr2, imem_rdata2, if_instr2, if_pc2, maddr2;
  logic        imem_req2, imem_rvalid2, if_valid2;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_err, misalign_err2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  pc_next_seq #(.RESET_PC(RPC0), .PC_STEP(32'd4)) dut (
    .CLK(CLK), .RST(RST), .pc_cur(pc_cur), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .br_taken(br_taken), .br_target(br_target)
`ifdef MISALIGN_TRAP_EN
    , .misalign_err(misalign_err)
`endif
  );

  pc_next_seq #(.RESET_PC(RPC2), .PC_STEP(32'd4)) dut_wrap (
    .CLK(CLK), .RST(RST), .pc_cur(pc_cur2), .pc_next(pc_next2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rvalid(imem_rvalid2),
    .imem_rdata(imem_rdata2), .if_valid(if_valid2), .if_ready(1'b1),
    .if_instr(if_instr2), .if_pc(if_pc2), .br_taken(1'b0), .br_target(32'h0)
`ifdef MISALIGN_TRAP_EN
    , .misalign_err(misalign_err2)
`endif
  );

  // PC registers: load every edge.
  always @(posedge CLK) pc_cur  <= pc_next;
  always @(posedge CLK) pc_cur2 <= pc_next2;

  // Main memory: response mem_delay cycles after the request cycle.
  logic [1:0]  mem_cnt = 2'd0;
  logic [1:0]  mem_delay = 2'd1;
  logic [31:0] mem_addr = 32'h0;
  always @(posedge CLK) begin
    if (imem_req) begin
      mem_cnt  <= mem_delay;
      mem_addr <= imem_addr;
    end else if (mem_cnt != 2'd0) begin
      mem_cnt <= mem_cnt - 2'd1;
    end
  end
  assign imem_rvalid = (mem_cnt == 2'd1);
  assign imem_rdata  = mem_addr ^ MAGIC;

  // Wrap-test memory: fixed single-cycle latency.
  always @(posedge CLK) begin
    imem_rvalid2 <= imem_req2;
    maddr2       <= imem_addr2;
  end
  assign imem_rdata2 = maddr2 ^ MAGIC;

  // Reference model: what the fetch unit owes the outside world.
  bit          m_boot, m_issue, m_out, m_drop, m_valid, m_mis;
  logic [31:0] m_pc, m_instr, m_ipc;
  logic [31:0] req_log[$];
  logic [31:0] wrap_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle: apply inputs, compare against the model, advance the model.
  task automatic body(input logic br, input logic [31:0] tgt, input logic rdy);
    logic [31:0] exp_next;
    br_taken = br; br_target = tgt; if_ready = rdy;
    #1;
    if (m_boot)                exp_next = RPC0;
    else if (br)               exp_next = {tgt[31:2], 2'b00};
    else if (m_valid && rdy)   exp_next = m_pc + 32'd4;
    else                       exp_next = m_pc;
    check("pc_next", pc_next, exp_next);
    check("pc_cur", pc_cur, m_pc);
    check("imem_req", 32'(imem_req), 32'(m_issue));
    if (m_issue) check("imem_addr", imem_addr, m_pc);
    check("if_valid", 32'(if_valid), 32'(m_valid));
    check("if_instr", if_instr, m_instr);
    check("if_pc", if_pc, m_ipc);
`ifdef MISALIGN_TRAP_EN
    check("misalign_err", 32'(misalign_err), 32'(m_mis));
`endif
    if (imem_req) req_log.push_back(imem_addr);
    if (imem_req2 && wrap_log.size() < 2) wrap_log.push_back(imem_addr2);
    if (m_boot) begin
      m_boot = 0; m_issue = 1;
    end else begin
      if (br && tgt[1:0] != 2'b00) m_mis = 1;
      if (br) begin
        if (m_issue) begin m_issue = 0; m_drop = 1; end
        else if (m_out) begin
          m_out = 0;
          if (imem_rvalid) m_issue = 1; else m_drop = 1;
        end else if (m_valid) begin m_valid = 0; m_issue = 1; end
      end else begin
        if (m_issue) begin m_issue = 0; m_out = 1; end
        else if (m_out) begin
          if (imem_rvalid) begin
            m_out = 0; m_valid = 1; m_instr = m_pc ^ MAGIC; m_ipc = m_pc;
          end
        end else if (m_drop) begin
          if (imem_rvalid) begin m_drop = 0; m_issue = 1; end
        end else if (m_valid && rdy) begin m_valid = 0; m_issue = 1; end
      end
    end
    m_pc = exp_next;
  endtask

  task automatic step(input logic br, input logic [31:0] tgt, input logic rdy);
    @(negedge CLK);
    body(br, tgt, rdy);
  endtask

  task automatic do_reset(input int unsigned cycles);
    @(negedge CLK);
    RST = 1'b1; br_taken = 1'b0; if_ready = 1'b0;
    m_boot = 1; m_issue = 0; m_out = 0; m_drop = 0; m_valid = 0; m_mis = 0;
    m_pc = RPC0; m_instr = '0; m_ipc = '0;
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_pc_next", pc_next, RPC0);
`ifdef MISALIGN_TRAP_EN
    check("rst_misalign", 32'(misalign_err), 32'd0);
`endif
    repeat (cycles) @(negedge CLK);
    RST = 1'b0;
    body(1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    bit found;
    logic br;
    br_taken = 1'b0; br_target = '0; if_ready = 1'b0;
    do_reset(3);

    // Sequential fetch with decode always ready.
    repeat (3) step(1'b0, 32'h0, 1'b1);
    check("first_valid", 32'(if_valid), 32'd1);
    check("first_instr", if_instr, 32'hDEAD_0000);
    check("first_pc", if_pc, 32'h0);
    repeat (5) step(1'b0, 32'h0, 1'b1);
    check("req_count", req_log.size(), 32'd3);
    if (req_log.size() >= 3) begin
      check("addr0", req_log[0], 32'h0);
      check("addr1", req_log[1], 32'h4);
      check("addr2", req_log[2], 32'h8);
    end

    // Decode stalls in HOLD at pc 0x8.
    repeat (5) begin
      step(1'b0, 32'h0, 1'b0);
      check("stall_valid", 32'(if_valid), 32'd1);
      check("stall_instr", if_instr, 32'hDEAD_0008);
      check("stall_pc", if_pc, 32'h8);
      check("stall_pc_cur", pc_cur, 32'h8);
      check("stall_req", 32'(imem_req), 32'd0);
    end

    // Redirect from HOLD, even with ready high.
    step(1'b1, 32'h100, 1'b1);
    mem_delay = 2'd3;
    step(1'b0, 32'h0, 1'b1);
    check("hold_redir_valid", 32'(if_valid), 32'd0);
    check("hold_redir_req", 32'(imem_req), 32'd1);
    check("hold_redir_addr", imem_addr, 32'h100);

    // Redirect from WAIT while the response is still three cycles out.
    step(1'b1, 32'h200, 1'b1);
    mem_delay = 2'd1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (imem_req) begin
        found = 1;
        check("wait_redir_addr", imem_addr, 32'h200);
      end else begin
        check("drop_valid", 32'(if_valid), 32'd0);
      end
    end
    if (!found) check("wait_redir_timeout", 32'd0, 32'd1);

    // Misaligned redirect target is masked.
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge CLK);
      if (m_valid) begin found = 1; body(1'b1, 32'h103, 1'b0); end
      else body(1'b0, 32'h0, 1'b0);
    end
    if (!found) check("hold_timeout", 32'd0, 32'd1);
    step(1'b0, 32'h0, 1'b1);
    check("mis_req", 32'(imem_req), 32'd1);
    check("mis_addr", imem_addr, 32'h100);
`ifdef MISALIGN_TRAP_EN
    check("mis_flag", 32'(misalign_err), 32'd1);
    repeat (4) step(1'b0, 32'h0, 1'b1);
    check("mis_sticky", 32'(misalign_err), 32'd1);
`endif
    do_reset(3);

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 119) == 0) begin
        do_reset(3);
      end else begin
        mem_delay = 2'($urandom_range(1, 3));
        @(negedge CLK);
        br = ($urandom_range(0, 7) == 0);
        // A redirect in DRAIN as the response lands would wait forever.
        if (m_drop && imem_rvalid) br = 1'b0;
        body(br, $urandom, 1'($urandom_range(0, 1)));
      end
    end

    // Wrap-around instance.
    check("wrap_count", wrap_log.size(), 32'd2);
    if (wrap_log.size() >= 2) begin
      check("wrap_addr0", wrap_log[0], 32'hFFFF_FFFC);
      check("wrap_addr1", wrap_log[1], 32'h0000_0000);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_next_seq.md
Name: pc_next_seq

Overview:
Next-PC sequencer and fetch controller that sits directly upstream of the PC register. It drives that register's D input and reads back its Q output. It issues one instruction-memory request per PC, holds the returned instruction for the decode stage under a valid/ready handshake, and applies branch/jump redirects. The PC register loads every CLK edge, so this block re-drives the current PC whenever fetch must not advance.

Parameters:
RESET_PC, 32'h0000_0000, first PC loaded into the PC register after reset
PC_STEP, 4, sequential increment in bytes

Ports:
CLK  input  1  rising-edge clock
RST  input  1  reset, asynchronous, active-high
pc_cur  input  32  current PC (Q of PC register)
pc_next  output  32  next PC (D of PC register)
imem_req  output  1  one-cycle request strobe to instruction memory
imem_addr  output  32  request address
imem_rvalid  input  1  response valid; at most one request outstanding
imem_rdata  input  32  response instruction
if_valid  output  1  instruction/PC pair valid to decode
if_ready  input  1  decode accepts pair
if_instr  output  32  held instruction
if_pc  output  32  PC of held instruction
br_taken  input  1  redirect request from execute
br_target  input  32  redirect target

Behaviour:
- One clock (CLK). Reset is asynchronous and active-high (RST).
- Reset values: state=BOOT, imem_req=0, if_valid=0, if_instr=0, if_pc=0. pc_next=RESET_PC (combinational in BOOT).
- Only if_instr, if_pc and state are registered. imem_req, imem_addr, pc_next and if_valid decode from state/inputs.
- BOOT: pc_next=RESET_PC, no request; go to ISSUE. br_taken is ignored in BOOT.
- ISSUE: imem_req=1, imem_addr=pc_cur, pc_next=pc_cur; go to WAIT.
- WAIT: pc_next=pc_cur. On imem_rvalid, capture if_instr<=imem_rdata and if_pc<=pc_cur, then go to HOLD.
- HOLD: if_valid=1. On if_ready, pc_next=pc_cur+PC_STEP and go to ISSUE. Otherwise pc_next=pc_cur and stay; if_instr/if_pc stay stable.
- DRAIN: pc_next=pc_cur. On imem_rvalid, discard the data and go to ISSUE.
- Redirect (br_taken=1, any state except BOOT) has priority over the handshake:
  - pc_next={br_target[31:2],2'b00}.
  - if_valid reads 0 from the next cycle.
  - From ISSUE: go to DRAIN (the request just issued is outstanding).
  - From WAIT with imem_rvalid in the same cycle: discard the data and go to ISSUE.
  - From WAIT without imem_rvalid: go to DRAIN.
  - From DRAIN: stay in DRAIN.
  - From HOLD: go to ISSUE, even if if_ready=1 that cycle (the pair is not considered consumed).
- Latency: RST deassert -> first imem_req is 2 cycles (BOOT, then ISSUE on the next edge). Throughput is 1 instruction per 3 cycles with a 1-cycle memory.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 -> 32'h0000_0000.
- RST mid-operation: a response arriving after reset is ignored, because BOOT/ISSUE do not sample imem_rvalid.
- imem_rvalid is ignored in ISSUE and HOLD.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- With the macro: adds output misalign_err (1 bit, reset 0). It is sticky-set when br_taken=1 and br_target[1:0]!=0 in a non-BOOT state, and cleared only by RST. Target masking is unchanged.
- Without the macro: no port; misaligned bits are masked silently.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding: BOOT, ISSUE, WAIT, HOLD, DRAIN (3-bit localparams).
  - XLEN=32.
  - ALIGN_MASK=32'hFFFF_FFFC.
- One natural sub-module, fetch_hold_reg: the if_instr/if_pc capture register with load enable and async reset.

Test Plan:
- Bench wires pc_next->PC register D and Q->pc_cur, with a 1-cycle memory returning instr=addr^32'hDEAD_0000.
- Reset, RESET_PC=0, if_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; if_instr of the first pair=0xDEAD_0000, if_pc=0x0.
- Hold: if_ready=0 for 5 cycles while in HOLD at pc 0x8 -> if_valid=1 and if_instr/if_pc unchanged, pc_cur stays 0x8, no imem_req.
- Redirect in HOLD to 0x100 -> if_valid=0 next cycle, next imem_addr=0x100.
- Redirect in WAIT to 0x200 with memory response delayed 3 cycles -> the stale response is dropped (if_valid stays 0), next imem_addr=0x200.
- Wrap: RESET_PC=32'hFFFF_FFFC, if_ready=1 -> second imem_addr=0x0.
- MISALIGN_TRAP_EN: br_target=0x103 -> imem_addr=0x100, misalign_err=1 until RST.
